dmc_interval_decoder: RTL and testbench

Parametrised successor to the per-line DMC decode block. It pops TDC edge-interval samples from the line's show-ahead async FIFO, removes the TDC offset, and classifies each interval as SHORT, LONG or SYNC (preamble violation). It decodes biphase-mark bits: LONG gives 0, SHORT+SHORT gives 1. It flags unpaired shorts as errors and can track the long interval adaptively. Sits between the async FIFO and DeScrambleDeMux, one instance per receive line.

---
 rtl/dmc_decode_pkg.sv | 24 ++
 rtl/dmc_interval_decoder_classify.sv | 32 +++
 rtl/dmc_interval_decoder.sv | 202 ++++++++++++++++++++
 tb/tb_dmc_interval_decoder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmc_decode_pkg.sv
// Shared types and default widths for the DMC receive-line decode path.
// The async FIFO wrapper uses the same default widths.
// Optional build macro: DMC_ADAPTIVE_JUDGE_EN (adaptive LONG threshold).
package dmc_decode_pkg;

    localparam int unsigned DMC_DATA_W = 6;
    localparam int unsigned DMC_ADDR_W = 4;

    // One-hot decode states
    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_PRIME = 4'b0010,
        ST_RUN   = 4'b0100,
        ST_DONE  = 4'b1000
    } dmc_state_e;

    // Interval classes
    typedef enum logic [1:0] {
        CLS_SHORT = 2'd0,
        CLS_LONG  = 2'd1,
        CLS_SYNC  = 2'd2
    } dmc_class_e;

endpackage

// File: rtl/dmc_interval_decoder_classify.sv
// Offset removal (saturating at 0) and SHORT/LONG/SYNC classification of one
// TDC interval sample. Purely combinational.
module dmc_interval_classify
    import dmc_decode_pkg::*;
#(
    parameter int unsigned DATA_W = DMC_DATA_W
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic [DATA_W-1:0] offset_i,
    input  logic [DATA_W-1:0] judge_i,
    input  logic [DATA_W-1:0] sync_judge_i,
    output logic [DATA_W-1:0] corr_o,
    output dmc_class_e        cls_o
);

    logic [DATA_W:0] diff;

    // Subtract offset with a borrow bit; negative results clamp to zero,
    // then compare strictly so equality falls to the lower class
    always_comb begin
        diff   = {1'b0, data_i} - {1'b0, offset_i};
        corr_o = diff[DATA_W] ? '0 : diff[DATA_W-1:0];
        if (corr_o > sync_judge_i) begin
            cls_o = CLS_SYNC;
        end else if (corr_o > judge_i) begin
            cls_o = CLS_LONG;
        end else begin
            cls_o = CLS_SHORT;
        end
    end

endmodule

// File: rtl/dmc_interval_decoder.sv
// Per-line DMC interval decoder: pops TDC interval samples from the show-ahead
// async FIFO, classifies them and decodes biphase-mark bits.
// Optional build macro: DMC_ADAPTIVE_JUDGE_EN tracks the LONG interval and
// derives the SHORT/LONG threshold from it instead of reg_judge.
module dmc_interval_decoder
    import dmc_decode_pkg::*;
#(
    parameter int unsigned DATA_W        = DMC_DATA_W,
    parameter int unsigned ADDR_W        = DMC_ADDR_W,
    parameter int unsigned AVG_SHIFT     = 3,
    parameter int unsigned EMPTY_TIMEOUT = 6,
    parameter int unsigned FPGA          = 0
) (
    input  logic              clk_i,
    input  logic              reset_n_period,
    input  logic              enable,
    input  logic [ADDR_W:0]   start_threshold,
    input  logic [DATA_W-1:0] tdc_offset,
    input  logic [DATA_W-1:0] reg_judge,
    input  logic [DATA_W-1:0] reg_sync_judge,
    input  logic [DATA_W-1:0] reg_long_init,
    input  logic [ADDR_W:0]   fifo_pop_size,
    input  logic              fifo_pop_empty,
    input  logic [DATA_W-1:0] fifo_popd_data,
    output logic              fifo_pop_en,
    output logic              bit_o,
    output logic              bit_vld,
    output logic              sync_o,
    output logic              err_o,
    output logic [7:0]        err_cnt,
    output logic              done_o,
    output logic [DATA_W-1:0] judge_cur
);

    localparam int unsigned CNT_W = $clog2(EMPTY_TIMEOUT + 1);

    if (AVG_SHIFT == 0 || AVG_SHIFT > 16 || EMPTY_TIMEOUT == 0) begin : g_bad_cfg
        $error("dmc_interval_decoder: AVG_SHIFT must be 1..16, EMPTY_TIMEOUT nonzero");
    end

    dmc_state_e        state_q;
    logic              half_q;
    logic [CNT_W-1:0]  empty_cnt_q;
    logic [7:0]        err_cnt_q;
    logic              bit_q;
    logic              bit_vld_q;
    logic              sync_q;
    logic              err_q;
    logic              done_q;

    logic              pop_take;
    logic [DATA_W-1:0] corr;
    dmc_class_e        cls;

    // Pop strobe; with FPGA=1 the FIFO ignores pops while empty, so the
    // decode below still only acts on cycles where a sample was present
    always_comb begin
        if (FPGA != 0) begin
            fifo_pop_en = (state_q == ST_RUN);
        end else begin
            fifo_pop_en = (state_q == ST_RUN) && !fifo_pop_empty;
        end
        pop_take = fifo_pop_en && !fifo_pop_empty;
    end

    dmc_interval_classify #(
        .DATA_W (DATA_W)
    ) u_classify (
        .data_i       (fifo_popd_data),
        .offset_i     (tdc_offset),
        .judge_i      (judge_cur),
        .sync_judge_i (reg_sync_judge),
        .corr_o       (corr),
        .cls_o        (cls)
    );

`ifdef DMC_ADAPTIVE_JUDGE_EN
    localparam int unsigned ACC_W = DATA_W + AVG_SHIFT;

    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_d;
    logic [DATA_W-1:0] avg_d;
    logic [DATA_W-1:0] judge_q;
    logic [DATA_W-1:0] judge_d;

    // Next long-average: seeded on PRIME entry, leaky-integrated on LONG pops;
    // the threshold is derived from the next value so it applies to the next sample
    always_comb begin
        acc_d = acc_q;
        if (enable && state_q == ST_IDLE) begin
            acc_d = ACC_W'(reg_long_init) << AVG_SHIFT;
        end else if (enable && state_q == ST_RUN && pop_take && cls == CLS_LONG) begin
            acc_d = acc_q - (acc_q >> AVG_SHIFT) + ACC_W'(corr);
        end
        avg_d   = DATA_W'(acc_d >> AVG_SHIFT);
        judge_d = avg_d - (avg_d >> 2);
    end

    // Accumulator and threshold registers
    always_ff @(posedge clk_i or negedge reset_n_period) begin
        if (!reset_n_period) begin
            acc_q   <= '0;
            judge_q <= '0;
        end else begin
            acc_q   <= acc_d;
            judge_q <= judge_d;
        end
    end

    assign judge_cur = judge_q;
`else
    assign judge_cur = reg_judge;
`endif

    // Decode FSM with empty-timeout counter, error counter and registered strobes
    always_ff @(posedge clk_i or negedge reset_n_period) begin
        if (!reset_n_period) begin
            state_q     <= ST_IDLE;
            half_q      <= 1'b0;
            empty_cnt_q <= '0;
            err_cnt_q   <= '0;
            bit_q       <= 1'b0;
            bit_vld_q   <= 1'b0;
            sync_q      <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            bit_vld_q <= 1'b0;
            sync_q    <= 1'b0;
            err_q     <= 1'b0;
            if (!enable) begin
                state_q     <= ST_IDLE;
                half_q      <= 1'b0;
                empty_cnt_q <= '0;
                done_q      <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        state_q     <= ST_PRIME;
                        err_cnt_q   <= '0;
                        half_q      <= 1'b0;
                        empty_cnt_q <= '0;
                    end
                    ST_PRIME: begin
                        if (fifo_pop_size >= start_threshold) begin
                            state_q <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (pop_take) begin
                            empty_cnt_q <= '0;
                            unique case (cls)
                                CLS_SHORT: begin
                                    if (half_q) begin
                                        bit_q     <= 1'b1;
                                        bit_vld_q <= 1'b1;
                                        half_q    <= 1'b0;
                                    end else begin
                                        half_q <= 1'b1;
                                    end
                                end
                                CLS_LONG: begin
                                    bit_q     <= 1'b0;
                                    bit_vld_q <= 1'b1;
                                    if (half_q) begin
                                        err_q  <= 1'b1;
                                        half_q <= 1'b0;
                                        if (err_cnt_q != 8'hFF) begin
                                            err_cnt_q <= err_cnt_q + 8'd1;
                                        end
                                    end
                                end
                                default: begin
                                    sync_q <= 1'b1;
                                    half_q <= 1'b0;
                                end
                            endcase
                        end else if (fifo_pop_empty) begin
                            empty_cnt_q <= empty_cnt_q + 1'b1;
                            if (empty_cnt_q == CNT_W'(EMPTY_TIMEOUT - 1)) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                                half_q  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        done_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bit_o   = bit_q;
    assign bit_vld = bit_vld_q;
    assign sync_o  = sync_q;
    assign err_o   = err_q;
    assign err_cnt = err_cnt_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_dmc_interval_decoder.sv
// Directed self-checking bench for dmc_interval_decoder (DATA_W=6, ADDR_W=4).
module tb_dmc_interval_decoder;

    logic       clk_i = 1'b0;
    logic       reset_n_period;
    logic       enable;
    logic [4:0] start_threshold;
    logic [5:0] tdc_offset;
    logic [5:0] reg_judge;
    logic [5:0] reg_sync_judge;
    logic [5:0] reg_long_init;
    logic [4:0] fifo_pop_size;
    logic       fifo_pop_empty;
    logic [5:0] fifo_popd_data;
    logic       fifo_pop_en;
    logic       bit_o;
    logic       bit_vld;
    logic       sync_o;
    logic       err_o;
    logic [7:0] err_cnt;
    logic       done_o;
    logic [5:0] judge_cur;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    dmc_interval_decoder #(
        .DATA_W        (6),
        .ADDR_W        (4),
        .AVG_SHIFT     (3),
        .EMPTY_TIMEOUT (6),
        .FPGA          (0)
    ) dut (
        .clk_i           (clk_i),
        .reset_n_period  (reset_n_period),
        .enable          (enable),
        .start_threshold (start_threshold),
        .tdc_offset      (tdc_offset),
        .reg_judge       (reg_judge),
        .reg_sync_judge  (reg_sync_judge),
        .reg_long_init   (reg_long_init),
        .fifo_pop_size   (fifo_pop_size),
        .fifo_pop_empty  (fifo_pop_empty),
        .fifo_popd_data  (fifo_popd_data),
        .fifo_pop_en     (fifo_pop_en),
        .bit_o           (bit_o),
        .bit_vld         (bit_vld),
        .sync_o          (sync_o),
        .err_o           (err_o),
        .err_cnt         (err_cnt),
        .done_o          (done_o),
        .judge_cur       (judge_cur)
    );

    typedef struct {
        logic [5:0] data;
        logic       vld;
        logic       bitv;
        logic       sync;
        logic       err;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic feed(input logic [5:0] d);
        fifo_pop_empty = 1'b0;
        fifo_popd_data = d;
        tick();
    endtask

    // Watchdog: the run is a fixed number of cycles, this only guards a stuck sim
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int err_pulses;
        int prev_judge;

        // {data, vld, bit, sync, err, err_cnt}; tdc_offset=2, judge=24, sync=40
        vecs[0]  = '{6'd18, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}; // corr16 SHORT, half set
        vecs[1]  = '{6'd18, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}; // SHORT pair -> 1
        vecs[2]  = '{6'd34, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}; // corr32 LONG -> 0
        vecs[3]  = '{6'd42, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}; // corr40 == sync judge -> LONG
        vecs[4]  = '{6'd43, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0}; // corr41 SYNC
        vecs[5]  = '{6'd18, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}; // half set
        vecs[6]  = '{6'd34, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1}; // unpaired short -> err
        vecs[7]  = '{6'd1,  1'b0, 1'b0, 1'b0, 1'b0, 8'd1}; // corr saturates to 0, SHORT
        vecs[8]  = '{6'd26, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1}; // corr24 == judge -> SHORT
        vecs[9]  = '{6'd18, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1}; // half set
        vecs[10] = '{6'd43, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1}; // SYNC drops half, no err
        vecs[11] = '{6'd34, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1}; // LONG with half clear
        vecs[12] = '{6'd27, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1}; // corr25 LONG
        vecs[13] = '{6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'd1}; // corr 0 SHORT
        vecs[14] = '{6'd0,  1'b1, 1'b1, 1'b0, 1'b0, 8'd1}; // pair -> 1

        reset_n_period  = 1'b0;
        enable          = 1'b0;
        start_threshold = 5'd3;
        tdc_offset      = 6'd2;
        reg_judge       = 6'd24;
        reg_sync_judge  = 6'd40;
        reg_long_init   = 6'd32;
        fifo_pop_size   = 5'd0;
        fifo_pop_empty  = 1'b1;
        fifo_popd_data  = 6'd0;
        tick(2);

        chk("rst_bit_vld", bit_vld, 0);
        chk("rst_bit_o", bit_o, 0);
        chk("rst_sync_o", sync_o, 0);
        chk("rst_err_o", err_o, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_done_o", done_o, 0);
        chk("rst_pop_en", fifo_pop_en, 0);
`ifdef DMC_ADAPTIVE_JUDGE_EN
        chk("rst_judge_cur", judge_cur, 0);
`else
        chk("rst_judge_cur", judge_cur, 24);
`endif

        reset_n_period = 1'b1;
        tick();

        // PRIME with fill below threshold: no pops even though data is present
        enable         = 1'b1;
        fifo_pop_size  = 5'd2;
        fifo_pop_empty = 1'b0;
        fifo_popd_data = 6'd18;
        tick(4);
        chk("prime_pop_en", fifo_pop_en, 0);
        chk("prime_bit_vld", bit_vld, 0);

        fifo_pop_size = 5'd3;
        tick();
        chk("run_pop_en", fifo_pop_en, 1);

        for (int i = 0; i < 15; i++) begin
            feed(vecs[i].data);
            chk($sformatf("vec%0d_vld", i), bit_vld, vecs[i].vld);
            if (vecs[i].vld) chk($sformatf("vec%0d_bit", i), bit_o, vecs[i].bitv);
            chk($sformatf("vec%0d_sync", i), sync_o, vecs[i].sync);
            chk($sformatf("vec%0d_err", i), err_o, vecs[i].err);
            chk($sformatf("vec%0d_cnt", i), err_cnt, vecs[i].cnt);
        end
`ifndef DMC_ADAPTIVE_JUDGE_EN
        chk("static_judge_cur", judge_cur, 24);
`endif

        // 300 unpaired-short pairs: err_cnt saturates at 255
        err_pulses = 0;
        for (int i = 0; i < 300; i++) begin
            feed(6'd18);
            feed(6'd34);
            if (err_o) err_pulses++;
            if (i == 252) chk("sat_cnt_254", err_cnt, 254);
        end
        chk("sat_err_pulses", err_pulses, 300);
        chk("sat_err_cnt", err_cnt, 255);

        // 4 empty cycles, then a sample on the 5th restarts the counter
        fifo_pop_empty = 1'b1;
        tick(4);
        chk("empty4_done", done_o, 0);
        feed(6'd18);
        fifo_pop_empty = 1'b1;
        tick(5);
        chk("restart_done_5", done_o, 0);
        tick();
        chk("timeout_done", done_o, 1);
        chk("timeout_no_err", err_o, 0);
        fifo_pop_empty = 1'b0;
        fifo_popd_data = 6'd34;
        tick(2);
        chk("done_held", done_o, 1);
        chk("done_pop_en", fifo_pop_en, 0);
        chk("done_no_vld", bit_vld, 0);

        // enable low from DONE: IDLE, done cleared, err_cnt retained
        enable = 1'b0;
        tick();
        chk("idle_done_clr", done_o, 0);
        chk("idle_pop_en", fifo_pop_en, 0);
        chk("idle_err_cnt_kept", err_cnt, 255);

        // Re-enable: PRIME entry clears err_cnt
        enable = 1'b1;
        tick();
        chk("prime_err_cnt_clr", err_cnt, 0);
        tick();
        feed(6'd18);
        chk("mid_half_no_vld", bit_vld, 0);

        // enable low mid-RUN with a completing short present: no output, pops stop
        fifo_popd_data = 6'd18;
        enable = 1'b0;
        chk("abort_pop_en_before", fifo_pop_en, 1);
        tick();
        chk("abort_no_vld", bit_vld, 0);
        chk("abort_pop_en", fifo_pop_en, 0);
        chk("abort_done", done_o, 0);

`ifdef DMC_ADAPTIVE_JUDGE_EN
        // Seed 32 -> threshold 24; LONG corr 40 drives it up to 30
        fifo_pop_empty = 1'b1;
        reg_long_init  = 6'd32;
        enable = 1'b1;
        tick();
        chk("adapt_seed_judge", judge_cur, 24);
        tick();
        prev_judge = judge_cur;
        for (int i = 0; i < 40; i++) begin
            feed(6'd42);
            chk("adapt_monotonic", (judge_cur >= prev_judge) ? 1 : 0, 1);
            prev_judge = judge_cur;
        end
        chk("adapt_final_judge", judge_cur, 30);
        feed(6'd29);
        chk("adapt_29_short", bit_vld, 0);
        feed(6'd18);
        chk("adapt_pair_vld", bit_vld, 1);
        chk("adapt_pair_bit", bit_o, 1);
`else
        prev_judge = 0;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
